// File: rtl/fft_pkg.sv
// Shared definitions for the FFT ingress path: sample layout, framing states,
// and the width of the completed-frame counter.
package fft_pkg;

    localparam int DATA_W      = 32;
    localparam int FRAME_CNT_W = 16;

    // Complex sample layout: {imag, real}, both two's complement.
    localparam int RE_LSB = 0;
    localparam int RE_MSB = 15;
    localparam int IM_LSB = 16;
    localparam int IM_MSB = 31;

    typedef enum logic {
        STREAM = 1'b0,
        PAD    = 1'b1
    } state_t;

    function automatic logic signed [RE_MSB-RE_LSB:0] sample_re(input logic [DATA_W-1:0] s);
        return s[RE_MSB:RE_LSB];
    endfunction

    function automatic logic signed [IM_MSB-IM_LSB:0] sample_im(input logic [DATA_W-1:0] s);
        return s[IM_MSB:IM_LSB];
    endfunction

endpackage

// File: rtl/fft_sample_fifo.sv
// Synchronous first-word-fall-through sample FIFO; the head entry is visible on
// rd_data whenever empty is low. Storage is not reset, only pointers and count.
module fft_sample_fifo import fft_pkg::*; #(
    parameter int DATA_W     = fft_pkg::DATA_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == DEPTH_L);
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    // Guard locally so a misbehaving caller cannot corrupt the pointers.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fft_input_ctrl.sv
// Ingress framer: buffers host samples and hands them to the FFT core in frames
// of FRAME_LEN with a last marker, zero-padding a partial frame on flush.
module fft_input_ctrl import fft_pkg::*; #(
    parameter int FRAME_LEN  = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = fft_pkg::DATA_W
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_data_valid,
    output logic                          o_data_ready,
    input  logic                          i_flush,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_data_valid,
    output logic                          o_data_last,
    input  logic                          i_data_ready,
    output logic [FRAME_CNT_W-1:0]        o_frame_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_busy
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [IDX_W-1:0]         idx;
    logic                     flush_pend;
    logic                     flush_nxt;
    logic [FRAME_CNT_W-1:0]   frame_cnt;
    logic                     rdy_en;

    logic                     push;
    logic                     pop;
    logic                     xfer;
    logic                     last;
    logic                     full;
    logic                     empty;
    logic [DATA_W-1:0]        head;

    fft_sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (push),
        .wr_data (i_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (o_level)
    );

    // Ready depends only on registered state, never on the downstream ready.
    assign o_data_ready = rdy_en && !full;
    assign push         = i_data_valid && o_data_ready;
    assign last         = (idx == IDX_LAST);
    assign pop          = (state == STREAM) && !empty && i_data_ready;
    assign xfer         = o_data_valid && i_data_ready;

    assign o_data_valid = (state == PAD) ? 1'b1 : !empty;
    assign o_data       = (state == STREAM && !empty) ? head : '0;
    assign o_data_last  = last && o_data_valid;
    assign o_frame_cnt  = frame_cnt;
    assign o_busy       = !empty || (idx != '0) || (state == PAD);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= STREAM;
            flush_pend <= 1'b0;
            idx        <= '0;
            frame_cnt  <= '0;
            rdy_en     <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_pend <= flush_nxt;
            rdy_en     <= 1'b1;
            if (xfer) begin
                idx <= last ? '0 : idx + 1'b1;
                if (last) frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Padding begins only once the FIFO has drained; a flush landing on a
    // frame boundary is simply dropped.
    always_comb begin
        state_nxt = state;
        flush_nxt = flush_pend;
        case (state)
            STREAM: begin
                if (i_flush) flush_nxt = 1'b1;
                if (flush_pend && empty) begin
                    if (idx != '0) state_nxt = PAD;
                    else           flush_nxt = 1'b0;
                end
            end
            PAD: begin
                if (xfer && last) begin
                    state_nxt = STREAM;
                    flush_nxt = 1'b0;
                end
            end
            default: state_nxt = STREAM;
        endcase
    end

endmodule

// File: tb/tb_fft_input_ctrl.sv
// Scoreboard bench for fft_input_ctrl with FRAME_LEN=8, FIFO_DEPTH=4.
module tb_fft_input_ctrl;

    localparam int FL = 8;
    localparam int FD = 4;
    localparam int DW = 32;

    logic                    clk = 1'b0;
    logic                    i_rst_n;
    logic [DW-1:0]           i_data;
    logic                    i_data_valid;
    logic                    o_data_ready;
    logic                    i_flush;
    logic [DW-1:0]           o_data;
    logic                    o_data_valid;
    logic                    o_data_last;
    logic                    i_data_ready;
    logic [15:0]             o_frame_cnt;
    logic [$clog2(FD):0]     o_level;
    logic                    o_busy;

    always #5 clk = ~clk;

    fft_input_ctrl #(
        .FRAME_LEN  (FL),
        .FIFO_DEPTH (FD),
        .DATA_W     (DW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .i_flush      (i_flush),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_data_last  (o_data_last),
        .i_data_ready (i_data_ready),
        .o_frame_cnt  (o_frame_cnt),
        .o_level      (o_level),
        .o_busy       (o_busy)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    int          exp_idx  = 0;
    int          exp_frames = 0;
    logic [32:0] sb_q[$];
    logic [32:0] mon_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected stream: each queued sample carries its own last flag.
    task automatic exp_sample(input logic [31:0] d);
        sb_q.push_back({(exp_idx == FL-1), d});
        if (exp_idx == FL-1) begin
            exp_idx = 0;
            exp_frames++;
        end else begin
            exp_idx++;
        end
    endtask

    task automatic exp_pad();
        while (exp_idx != 0) exp_sample(32'h0);
    endtask

    always @(negedge clk) begin
        if (i_rst_n && o_data_valid && i_data_ready) begin
            check("sb_has_entry", (sb_q.size() != 0), 1'b1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("out_data", o_data, mon_e[31:0]);
                check("out_last", o_data_last, mon_e[32]);
                n_out++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_one(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        i_data = d;
        i_data_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = o_data_ready;
            @(posedge clk);
            #2;
        end
        i_data_valid = 1'b0;
        check("push_accepted", ok, 1'b1);
        if (ok) exp_sample(d);
    endtask

    task automatic do_flush();
        i_flush = 1'b1;
        @(posedge clk);
        #2;
        i_flush = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !o_busy) done = 1'b1;
        end
        check(tag, {(sb_q.size() == 0), o_busy}, 2'b10);
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, o_data_ready, 1'b0);
        check({tag, "_valid"}, o_data_valid, 1'b0);
        check({tag, "_last"},  o_data_last, 1'b0);
        check({tag, "_data"},  o_data, 32'h0);
        check({tag, "_frames"}, o_frame_cnt, 16'h0);
        check({tag, "_level"}, o_level, 3'h0);
        check({tag, "_busy"},  o_busy, 1'b0);
    endtask

    initial begin
        int out_before;
        i_rst_n = 1'b0;
        i_data = '0;
        i_data_valid = 1'b0;
        i_flush = 1'b0;
        i_data_ready = 1'b0;
        cycles(3);
        check_reset_outputs("reset");
        i_rst_n = 1'b1;
        cycles(1);
        check("ready_after_reset", o_data_ready, 1'b1);

        // Two full frames, back to back
        i_data_ready = 1'b1;
        check("valid_before_push", o_data_valid, 1'b0);
        push_one(32'h0001_0000);
        check("first_latency", o_data_valid, 1'b1);
        for (int k = 2; k <= 16; k++) push_one(32'(k) << 16);
        wait_idle("idle_stream");
        check("frames_stream", o_frame_cnt, exp_frames);
        check("outputs_stream", n_out, 16);

        // Backpressure fills the FIFO
        i_data_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_one(32'h0000_0100 + 32'(k));
        i_data = 32'h0000_0105;
        i_data_valid = 1'b1;
        @(negedge clk);
        check("full_ready", o_data_ready, 1'b0);
        check("full_level", o_level, 3'd4);
        @(posedge clk);
        #2;
        i_data_valid = 1'b0;
        i_data_ready = 1'b1;
        @(negedge clk);
        check("ready_before_pop", o_data_ready, 1'b0);
        @(posedge clk);
        #2;
        check("ready_after_pop", o_data_ready, 1'b1);
        check("level_after_pop", o_level, 3'd3);
        exp_pad();
        do_flush();
        wait_idle("idle_backpressure");
        check("frames_backpressure", o_frame_cnt, exp_frames);

        // Short frame closed by flush
        for (int k = 1; k <= 3; k++) push_one(32'h0000_0200 + 32'(k));
        exp_pad();
        do_flush();
        wait_idle("idle_flush");
        check("frames_flush", o_frame_cnt, exp_frames);

        // Flush at a frame boundary does nothing and does not linger
        out_before = n_out;
        do_flush();
        cycles(4);
        check("boundary_no_output", n_out, out_before);
        check("boundary_frames", o_frame_cnt, exp_frames);
        check("boundary_busy", o_busy, 1'b0);
        for (int k = 1; k <= 3; k++) push_one(32'h0000_0300 + 32'(k));
        cycles(10);
        check("boundary_partial_busy", o_busy, 1'b1);
        check("boundary_partial_drained", sb_q.size(), 0);
        exp_pad();
        do_flush();
        wait_idle("idle_boundary");

        // Flush with samples queued, new samples pushed during padding
        for (int k = 1; k <= 3; k++) push_one(32'h0000_0400 + 32'(k));
        cycles(3);
        i_data_ready = 1'b0;
        push_one(32'h0000_0410);
        push_one(32'h0000_0411);
        exp_pad();
        do_flush();
        i_data_ready = 1'b1;
        cycles(3);
        for (int k = 0; k < 4; k++) push_one(32'h0000_0420 + 32'(k));
        exp_pad();
        do_flush();
        wait_idle("idle_pad_push");
        check("frames_pad_push", o_frame_cnt, exp_frames);

        // Reset mid-frame discards everything
        for (int k = 0; k < 5; k++) push_one(32'h0000_0500 + 32'(k));
        cycles(3);
        i_data_ready = 1'b0;
        push_one(32'h0000_0510);
        push_one(32'h0000_0511);
        i_rst_n = 1'b0;
        sb_q.delete();
        exp_idx = 0;
        exp_frames = 0;
        cycles(1);
        check_reset_outputs("midreset");
        i_rst_n = 1'b1;
        i_data_ready = 1'b1;
        cycles(1);
        check("ready_after_midreset", o_data_ready, 1'b1);
        for (int k = 0; k < 8; k++) push_one(32'h0000_0600 + 32'(k));
        wait_idle("idle_after_reset");
        check("frames_after_reset", o_frame_cnt, exp_frames);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_input_ctrl.md
# fft_input_ctrl

Ingress framer for the FFT datapath: accepts 32-bit complex samples from the host-side stream, buffers them in a small FIFO, and presents them to the FFT core's input stream in frames of exactly FRAME_LEN samples with a last-sample marker. A flush request zero-pads a partially filled frame so the core never stalls mid-frame. It is the counterpart of the output controller at the far end of the FFT/multiplier chain.

## Interface
- FRAME_LEN, 64: samples per FFT frame; power of 2, ≥2.
- FIFO_DEPTH, 16: sample buffer depth; power of 2, ≥2.
- DATA_W, 32: sample width; {imag[31:16], real[15:0]}, two's complement.

- i_clk  in  1  single clock; all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_data  in  DATA_W  upstream sample.
- i_data_valid  in  1  upstream sample valid.
- o_data_ready  out  1  block can accept a sample (= FIFO not full).
- i_flush  in  1  single-cycle request: complete current partial frame with zeros.
- o_data  out  DATA_W  sample to FFT core.
- o_data_valid  out  1  o_data valid.
- o_data_last  out  1  marks sample FRAME_LEN-1 of a frame; qualified by o_data_valid.
- i_data_ready  in  1  FFT core accepts sample.
- o_frame_cnt  out  16  completed frames; wraps 65535→0.
- o_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_busy  out  1  FIFO non-empty, or frame partially sent, or padding.

## Operation
- Push = i_data_valid && o_data_ready; pop/transfer = o_data_valid && i_data_ready.
- o_data_ready = !full, driven from registered occupancy only; no combinational path from i_data_ready.
- FIFO: first-word-fall-through, registered storage; simultaneous push+pop leaves o_level unchanged.
- Sample index idx counts 0..FRAME_LEN-1, advances on each transfer, wraps to 0; o_data_last = (idx == FRAME_LEN-1). On a last transfer o_frame_cnt increments.
- States: STREAM, PAD.
  - STREAM: o_data_valid = !empty, o_data = FIFO head.
  - PAD: o_data_valid = 1, o_data = 0; FIFO not popped, pushes still accepted.
- i_flush sets flush_pend (further i_flush while flush_pend set or in PAD: no effect).
- STREAM with flush_pend and empty (registered value this cycle): idx≠0 → PAD next cycle; idx=0 → clear flush_pend, stay STREAM, emit nothing.
- PAD: on last transfer → STREAM, clear flush_pend. Samples pushed while in PAD or on the entry cycle belong to the next frame.
- flush_pend with FIFO non-empty: keep streaming real samples; padding starts only once FIFO drains.
- o_busy = !empty || idx≠0 || state==PAD.

## Timing
- Reset (i_rst_n low at a clock edge): state STREAM, idx 0, flush_pend 0, FIFO empty; outputs o_data_ready 0 while reset held, o_data_valid 0, o_data_last 0, o_data 0, o_frame_cnt 0, o_level 0, o_busy 0. o_data_ready = 1 on the first cycle after release.
- Reset mid-frame discards FIFO contents, partial frame and pending flush; no padding emitted.
- Latency: sample pushed at cycle t is presented (o_data_valid) at t+1 if FIFO was empty.
- Throughput: one sample per cycle sustained with both sides ready.
- o_data/o_data_valid/o_data_last held stable while o_data_valid && !i_data_ready.
- Flush from empty FIFO, idx≠0: i_flush at t → PAD at t+1 (flush_pend sampled t+1, PAD visible t+2 worst case); pad samples one per ready cycle.

## Structure
- fft_pkg: DATA_W, sample field slices (real/imag), state enum {STREAM, PAD}, frame counter width (16).
- Sub-module fft_sample_fifo: parameterised sync FWFT FIFO (DATA_W, FIFO_DEPTH) with full/empty/level; framing FSM, idx, flush logic stay in fft_input_ctrl.

## Test plan (FRAME_LEN=8, FIFO_DEPTH=4)
- Stream 16 samples 0x0001_0000..0x0010_0000, i_data_ready=1 → 16 outputs in order, o_data_last on 8th and 16th, o_frame_cnt=2, first o_data_valid one cycle after first push.
- i_data_ready=0, push 5 samples → 4 accepted, o_data_ready=0, o_level=4; raise i_data_ready → all 4 out in order, o_data_ready returns 1 the cycle after first pop.
- Send 3 samples, i_flush → samples 1-3 then 5 zeros, last on 8th, o_frame_cnt=1, o_busy=0 afterwards.
- i_flush at idx=0 with empty FIFO → no output, o_frame_cnt unchanged, flush_pend cleared.
- 3 samples sent, i_flush while 2 more still queued, push 4 during PAD → 5 real + 3 zeros (frame 1), then the 4 new samples start frame 2 at idx 0.
- Assert reset after 5 of 8 samples with 2 queued → all outputs at reset values, next 8 pushed samples form a complete frame with last on 8th.
